// File: rtl/aexm_pkg.sv
// Shared aexm definitions: pipe-control state encodings, ALU select codes and
// the enable bundle produced by the pipe sequencer.
package aexm_pkg;

    localparam logic [1:0] CTL_RUN   = 2'd0;
    localparam logic [1:0] CTL_BSF2  = 2'd1;
    localparam logic [1:0] CTL_DWAIT = 2'd2;

    // MXALU class codes, shared with decode and execute
    localparam logic [2:0] MXALU_ADD = 3'o0;
    localparam logic [2:0] MXALU_LOG = 3'o1;
    localparam logic [2:0] MXALU_SHF = 3'o2;
    localparam logic [2:0] MXALU_MUL = 3'o3;
    localparam logic [2:0] MXALU_BRA = 3'o4;
    localparam logic [2:0] MXALU_BSF = 3'o5;
    localparam logic [2:0] MXALU_SPR = 3'o6;
    localparam logic [2:0] MXALU_MOV = 3'o7;

    typedef struct packed {
        logic d_en;
        logic x_en;
        logic dbus_err;
    } ctl_out_t;

    function automatic logic is_bsf(input logic [2:0] mxalu);
        return mxalu == MXALU_BSF;
    endfunction

endpackage

// File: rtl/aexm_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module aexm_sat_cnt #(
    parameter int W = 16
) (
    input  logic         gclk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge gclk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/aexm_pipe_ctl.sv
// Pipeline enable sequencer: stalls decode/execute for two-cycle barrel shifts,
// outstanding data-cache accesses (with timeout) and fetch starvation.
module aexm_pipe_ctl
    import aexm_pkg::*;
#(
    parameter int BSF  = 0,
    parameter int DTMO = 255,
    parameter int CW   = 16
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          i_ready,
    input  logic [2:0]    x_mxalu,
    input  logic          x_skip,
    input  logic          x_dreq,
    input  logic          dc_ack,
    output logic          d_en,
    output logic          x_en,
    output logic          dbus_err,
    output logic [CW-1:0] stall_cnt,
    output logic [1:0]    ctl_state
);

    localparam int TW = (DTMO < 2) ? 1 : $clog2(DTMO + 1);
    localparam logic [TW-1:0] TMO = TW'(DTMO);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;
    ctl_out_t      ctl;
    logic          bsf;
    logic          dmiss;

    assign bsf   = (BSF != 0) && is_bsf(x_mxalu) && !x_skip;
    assign dmiss = x_dreq && !x_skip && !dc_ack;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        ctl     = '0;
        case (state_q)
            CTL_RUN: begin
                if (bsf) begin
                    state_d = CTL_BSF2;
                end else if (dmiss) begin
                    tmo_d   = TW'(1);
                    state_d = CTL_DWAIT;
                end else if (i_ready) begin
                    ctl.x_en = 1'b1;
                    ctl.d_en = 1'b1;
                end
            end
            CTL_BSF2: begin
                ctl.x_en = 1'b1;
                ctl.d_en = i_ready;
                state_d  = CTL_RUN;
            end
            CTL_DWAIT: begin
                // the issued access must finish, so x_skip is ignored here
                if (dc_ack) begin
                    ctl.x_en = 1'b1;
                    ctl.d_en = i_ready;
                    state_d  = CTL_RUN;
                end else if ((DTMO != 0) && (tmo_q == TMO)) begin
                    ctl.dbus_err = 1'b1;
                    ctl.x_en     = 1'b1;
                    ctl.d_en     = i_ready;
                    state_d      = CTL_RUN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = CTL_RUN;
        endcase
        if (grst) begin
            ctl     = '0;
            state_d = CTL_RUN;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge gclk) begin
        state_q <= state_d;
        tmo_q   <= tmo_d;
    end

    aexm_sat_cnt #(
        .W(CW)
    ) u_stall_cnt (
        .gclk  (gclk),
        .clr_i (grst),
        .inc_i (!ctl.x_en),
        .cnt_o (stall_cnt)
    );

    assign d_en      = ctl.d_en;
    assign x_en      = ctl.x_en;
    assign dbus_err  = ctl.dbus_err;
    assign ctl_state = state_q;

endmodule

// File: tb/tb_aexm_pipe_ctl.sv
// Scoreboard bench: instance A (BSF=1, DTMO=8, CW=16) and instance B (BSF=0, DTMO=8, CW=4)
// share one stimulus stream; each cycle's hand-computed enables are queued and checked.
module tb_aexm_pipe_ctl;

    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic       grst    = 1'b1;
    logic       i_ready = 1'b1;
    logic [2:0] x_mxalu = 3'd0;
    logic       x_skip  = 1'b0;
    logic       x_dreq  = 1'b0;
    logic       dc_ack  = 1'b0;

    logic        d_en_a, x_en_a, err_a;
    logic [15:0] cnt_a;
    logic [1:0]  st_a;
    logic        d_en_b, x_en_b, err_b;
    logic [3:0]  cnt_b;
    logic [1:0]  st_b;

    aexm_pipe_ctl #(.BSF(1), .DTMO(8), .CW(16)) u_dut_a (
        .gclk(gclk), .grst(grst), .i_ready(i_ready), .x_mxalu(x_mxalu),
        .x_skip(x_skip), .x_dreq(x_dreq), .dc_ack(dc_ack),
        .d_en(d_en_a), .x_en(x_en_a), .dbus_err(err_a),
        .stall_cnt(cnt_a), .ctl_state(st_a)
    );

    aexm_pipe_ctl #(.BSF(0), .DTMO(8), .CW(4)) u_dut_b (
        .gclk(gclk), .grst(grst), .i_ready(i_ready), .x_mxalu(x_mxalu),
        .x_skip(x_skip), .x_dreq(x_dreq), .dc_ack(dc_ack),
        .d_en(d_en_b), .x_en(x_en_b), .dbus_err(err_b),
        .stall_cnt(cnt_b), .ctl_state(st_b)
    );

    // expected {d_en, x_en, dbus_err}
    localparam logic [2:0] E_RUN = 3'b110;
    localparam logic [2:0] E_STL = 3'b000;
    localparam logic [2:0] E_RET = 3'b010;
    localparam logic [2:0] E_ERR = 3'b111;

    typedef struct {
        string      tag;
        logic [2:0] ea;
        logic [2:0] eb;
        int         sa;
        int         ca;
        int         cb;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cnt_a_m = 0;
    int   cnt_b_m = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input string tag, input bit rst, input bit ir, input logic [2:0] mx,
                        input bit sk, input bit dr, input bit ak,
                        input logic [2:0] ea, input logic [2:0] eb, input int sa);
        exp_t e;
        @(posedge gclk);
        #1;
        grst    = rst;
        i_ready = ir;
        x_mxalu = mx;
        x_skip  = sk;
        x_dreq  = dr;
        dc_ack  = ak;
        e.tag = tag;
        e.ea  = ea;
        e.eb  = eb;
        e.sa  = sa;
        e.ca  = cnt_a_m;
        e.cb  = cnt_b_m;
        q.push_back(e);
        // stall counters shown next cycle accumulate this cycle's expected x_en
        if (rst) begin
            cnt_a_m = 0;
            cnt_b_m = 0;
        end else begin
            if (!ea[1]) cnt_a_m++;
            if (!eb[1] && cnt_b_m < 15) cnt_b_m++;
        end
    endtask

    always @(negedge gclk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            $display("%-12s A den/xen/err=%b%b%b cnt=%0d st=%0d | B=%b%b%b cnt=%0d",
                     m_e.tag, d_en_a, x_en_a, err_a, cnt_a, st_a, d_en_b, x_en_b, err_b, cnt_b);
            chk({m_e.tag, " A enables"}, int'({d_en_a, x_en_a, err_a}), int'(m_e.ea));
            chk({m_e.tag, " A stall_cnt"}, int'(cnt_a), m_e.ca);
            if (m_e.sa >= 0)
                chk({m_e.tag, " A ctl_state"}, int'(st_a), m_e.sa);
            chk({m_e.tag, " B enables"}, int'({d_en_b, x_en_b, err_b}), int'(m_e.eb));
            chk({m_e.tag, " B stall_cnt"}, int'(cnt_b), m_e.cb);
        end
    end

    initial begin
        // reset then idle
        repeat (3) step("rst", 1, 1, 0, 0, 0, 0, E_STL, E_STL, 0);
        step("idle", 0, 1, 0, 0, 0, 0, E_RUN, E_RUN, 0);
        // barrel shift: A stalls one cycle, B does not
        step("bsf1", 0, 1, 5, 0, 0, 0, E_STL, E_RUN, 0);
        step("bsf2", 0, 1, 5, 0, 0, 0, E_RUN, E_RUN, 1);
        step("bsf_post", 0, 1, 0, 0, 0, 0, E_RUN, E_RUN, 0);
        for (int i = 0; i < 4; i++)
            step("b2b", 0, 1, 5, 0, 0, 0, (i % 2) ? E_RUN : E_STL, E_RUN, i % 2);
        step("bsf_starve", 0, 0, 5, 0, 0, 0, E_STL, E_STL, 0);
        step("bsf2_starve", 0, 0, 5, 0, 0, 0, E_RET, E_STL, 1);
        step("bsf_skip", 0, 1, 5, 1, 0, 0, E_RUN, E_RUN, 0);
        // cache hit and annulled access
        step("hit", 0, 1, 0, 0, 1, 1, E_RUN, E_RUN, 0);
        step("dreq_skip", 0, 1, 0, 1, 1, 0, E_RUN, E_RUN, 0);
        // cache miss, ack on the 5th DWAIT cycle; x_skip mid-wait must not abort
        step("miss_entry", 0, 1, 0, 0, 1, 0, E_STL, E_STL, 0);
        for (int i = 1; i <= 4; i++)
            step("miss_wait", 0, 1, 0, (i == 2), 1, 0, E_STL, E_STL, 2);
        step("miss_ack", 0, 0, 0, 0, 1, 1, E_RET, E_RET, 2);
        step("miss_post", 0, 1, 0, 0, 0, 0, E_RUN, E_RUN, 0);
        // timeout without ack
        step("tmo_entry", 0, 1, 0, 0, 1, 0, E_STL, E_STL, 0);
        repeat (7) step("tmo_wait", 0, 1, 0, 0, 1, 0, E_STL, E_STL, 2);
        step("tmo_err", 0, 1, 0, 0, 1, 0, E_ERR, E_ERR, 2);
        step("tmo_post", 0, 1, 0, 0, 0, 0, E_RUN, E_RUN, 0);
        // ack coinciding with timeout wins
        step("tack_entry", 0, 1, 0, 0, 1, 0, E_STL, E_STL, 0);
        repeat (7) step("tack_wait", 0, 1, 0, 0, 1, 0, E_STL, E_STL, 2);
        step("tack_ack", 0, 1, 0, 0, 1, 1, E_RUN, E_RUN, 2);
        step("tack_post", 0, 1, 0, 0, 0, 0, E_RUN, E_RUN, 0);
        // fetch starvation
        repeat (3) step("starve", 0, 0, 0, 0, 0, 0, E_STL, E_STL, 0);
        step("fed", 0, 1, 0, 0, 0, 0, E_RUN, E_RUN, 0);
        // reset in the 2nd DWAIT cycle discards the pending ack
        step("rd_entry", 0, 1, 0, 0, 1, 0, E_STL, E_STL, 0);
        step("rd_wait", 0, 1, 0, 0, 1, 0, E_STL, E_STL, 2);
        step("rd_rst", 1, 1, 0, 0, 1, 1, E_STL, E_STL, 2);
        step("rd_post", 0, 1, 0, 0, 0, 0, E_RUN, E_RUN, 0);
        // saturation: B (CW=4) stops at 15, A keeps counting
        repeat (20) step("sat_starve", 0, 0, 0, 0, 0, 0, E_STL, E_STL, 0);
        step("sat_fed", 0, 1, 0, 0, 0, 0, E_RUN, E_RUN, 0);
        step("sat_idle", 0, 1, 0, 0, 0, 0, E_RUN, E_RUN, 0);

        repeat (3) @(negedge gclk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
